// File: rtl/vend_dispense_arbiter_if.sv
// ----------------------------------------------------------------------------
// vend_dispense_arbiter_if
// Bundle between the vending front panels and the shared dispense arbiter.
//
// Handshake: a panel raises req[i] together with stable req_price/req_credit
// slices and holds them until it sees grant[i] or reject[i] (both 1-cycle
// pulses). done[i] pulses once when the vend and change payout finish.
// Requests are ignored while busy is high; only the values present in the
// arbitration cycle are used.
//
//   req        panels  -> arbiter  per-panel request
//   req_price  panels  -> arbiter  packed prices, panel i at [i*CREDIT_W +: CREDIT_W]
//   req_credit panels  -> arbiter  packed credits, same packing
//   grant      arbiter -> panels   one-hot pulse, request accepted
//   reject     arbiter -> panels   one-hot pulse, credit below price
//   done       arbiter -> panels   one-hot pulse, vend and change complete
//   motor_on   arbiter -> motor    dispense motor drive
//   coin_out   arbiter -> hopper   one pulse per change coin
//   busy       arbiter -> panels   high whenever a vend is in progress
// ----------------------------------------------------------------------------
interface vend_dispense_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int CREDIT_W = 8
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*CREDIT_W-1:0] req_price;
    logic [NUM_REQ*CREDIT_W-1:0] req_credit;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          reject;
    logic [NUM_REQ-1:0]          done;
    logic                        motor_on;
    logic                        coin_out;
    logic                        busy;

    modport master (
        output req, req_price, req_credit,
        input  grant, reject, done, motor_on, coin_out, busy
    );

    modport slave (
        input  req, req_price, req_credit,
        output grant, reject, done, motor_on, coin_out, busy
    );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// ----------------------------------------------------------------------------
// vend_dispense_arbiter
// Round-robin arbiter sharing one dispense motor and one change hopper
// between NUM_REQ front panels. The winner's credit is checked against its
// price; accepted requests drive the motor for VEND_CYCLES cycles, then
// change is paid out one COIN_VALUE coin at a time with a one-cycle gap
// between coins, and done is pulsed to the winner.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   bus        slave side of vend_dispense_arbiter_if (requests in,
//              grant/reject/done/motor_on/coin_out/busy out, all registered)
//   dbg_state  current FSM state (0 IDLE, 1 VEND, 2 CHANGE_PULSE,
//              3 CHANGE_GAP, 4 FINISH)
// ----------------------------------------------------------------------------
module vend_dispense_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CREDIT_W    = 8,
    parameter int VEND_CYCLES = 16,
    parameter int COIN_VALUE  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    vend_dispense_arbiter_if.slave  bus,
    output logic [2:0]              dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(VEND_CYCLES) + 1;
    localparam logic [CNT_W-1:0]    VEND_LAST = CNT_W'(VEND_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] COIN      = CREDIT_W'(COIN_VALUE);
    localparam logic [PTR_W-1:0]    LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_VEND         = 3'd1,
        S_CHANGE_PULSE = 3'd2,
        S_CHANGE_GAP   = 3'd3,
        S_FINISH       = 3'd4
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    winner;
    logic [CREDIT_W-1:0] price_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] change_left;
    logic [CNT_W-1:0]    vend_cnt;

    assign dbg_state = state;

    // Round-robin pick: first asserted request scanning from rr_ptr upward,
    // wrapping modulo NUM_REQ.
    logic             found;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] scan_idx;
    int               scan_sum;

    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr;
        scan_sum = 0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = int'(rr_ptr) + i;
            if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
            scan_idx = PTR_W'(scan_sum);
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    logic [CREDIT_W-1:0] pick_price;
    logic [CREDIT_W-1:0] pick_credit;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [NUM_REQ-1:0]  winner_onehot;
    logic [CREDIT_W-1:0] change_total;

    assign pick_price    = bus.req_price[int'(pick)*CREDIT_W +: CREDIT_W];
    assign pick_credit   = bus.req_credit[int'(pick)*CREDIT_W +: CREDIT_W];
    assign pick_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    // Only evaluated for granted requests, so credit_q >= price_q holds.
    assign change_total  = credit_q - price_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        return (w == LAST_IDX) ? '0 : w + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            winner       <= '0;
            price_q      <= '0;
            credit_q     <= '0;
            change_left  <= '0;
            vend_cnt     <= '0;
            bus.grant    <= '0;
            bus.reject   <= '0;
            bus.done     <= '0;
            bus.motor_on <= 1'b0;
            bus.coin_out <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            bus.grant    <= '0;
            bus.reject   <= '0;
            bus.done     <= '0;
            bus.coin_out <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (found) begin
                        winner   <= pick;
                        price_q  <= pick_price;
                        credit_q <= pick_credit;
                        if (pick_credit >= pick_price) begin
                            bus.grant    <= pick_onehot;
                            bus.motor_on <= 1'b1;
                            bus.busy     <= 1'b1;
                            vend_cnt     <= '0;
                            state        <= S_VEND;
                        end else begin
                            // Rejection leaves us idle so the next edge can
                            // arbitrate again.
                            bus.reject <= pick_onehot;
                            rr_ptr     <= next_ptr(pick);
                        end
                    end
                end

                S_VEND: begin
                    if (vend_cnt == VEND_LAST) begin
                        bus.motor_on <= 1'b0;
                        change_left  <= change_total;
                        if (change_total >= COIN) begin
                            bus.coin_out <= 1'b1;
                            state        <= S_CHANGE_PULSE;
                        end else begin
                            bus.done <= winner_onehot;
                            state    <= S_FINISH;
                        end
                    end else begin
                        vend_cnt <= vend_cnt + 1'b1;
                    end
                end

                S_CHANGE_PULSE: begin
                    change_left <= change_left - COIN;
                    state       <= S_CHANGE_GAP;
                end

                S_CHANGE_GAP: begin
                    // Any remainder below one coin is forfeited.
                    if (change_left >= COIN) begin
                        bus.coin_out <= 1'b1;
                        state        <= S_CHANGE_PULSE;
                    end else begin
                        bus.done <= winner_onehot;
                        state    <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    bus.busy <= 1'b0;
                    rr_ptr   <= next_ptr(winner);
                    state    <= S_IDLE;
                end

                default: begin
                    bus.busy     <= 1'b0;
                    bus.motor_on <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end
endmodule
